dbg_trigger_unit: RTL and testbench
===================================

Name: dbg_trigger_unit

Overview:
- Hardware trigger (breakpoint) unit that sits directly upstream of the core debug-mode controller.
- Compares the execute-stage PC and the load/store address against software-programmed triggers.
- On a match it drives the single-cycle `breakpoint` pulse consumed by the debug-mode controller.
- Triggers are programmed through the tselect/tdata1/tdata2 CSRs (0x7A0/0x7A1/0x7A2), using an mcontrol (type 2) subset.

Parameters:
- TRIG_NUM, 2, number of triggers (1..4).
- ADDR_W, 32, PC/data address width.

Ports:
- cpu_clk  input  1  core clock.
- cpu_rstn  input  1  asynchronous active-low reset.
- dbg_mode  input  1  core is in debug mode; triggers are suppressed while high.
- csr_addr  input  12  CSR address.
- csr_wr  input  1  CSR write strobe, single cycle.
- csr_wdata  input  32  CSR write data.
- csr_rdata  output  32  combinational read data; 0 for unmapped addresses.
- ex_valid  input  1  execute-stage instruction valid.
- ex_pc  input  ADDR_W  execute-stage PC.
- mem_valid  input  1  load/store access valid.
- mem_we  input  1  1 = store, 0 = load.
- mem_addr  input  ADDR_W  data address.
- breakpoint  output  1  registered one-cycle request to enter debug mode.
- trig_hit_idx  output  2  index of the trigger that caused the last breakpoint.

Behaviour:
- Reset is asynchronous on cpu_rstn low; clock is cpu_clk. All reset values are 0:
  - breakpoint=0, trig_hit_idx=0, tselect=0.
  - Every tdata1 fields and tdata2=0.
- tdata1 field layout per trigger:
  - type[31:28]: read-only constant 2.
  - dmode[27], hit[20], action[15:12], chain[11], m[6], execute[2], store[1], load[0].
  - All other bits read 0 and ignore writes.
  - action is stored as 1 bit: written value 1 stores 1, any other value stores 0.
- tselect:
  - A write of a value >= TRIG_NUM is ignored; the previous value is kept.
  - Reads return the current value.
  - tdata1/tdata2 accesses target trigger[tselect].
- dmode protection:
  - If the selected trigger has dmode=1 and dbg_mode=0, writes to its tdata1/tdata2 are ignored.
  - dmode itself is writable only while dbg_mode=1.
- Raw match for trigger i (match type is equality only), with m=1 required in every case:
  - Execute match: execute=1, ex_valid=1 and ex_pc==tdata2.
  - Store match: store=1, mem_valid=1, mem_we=1 and mem_addr==tdata2.
  - Load match: load=1, mem_valid=1, mem_we=0 and mem_addr==tdata2.
- Chaining:
  - Trigger i with chain=1 fires only if trigger i+1 also raw-matches in the same cycle.
  - The chain bit of the last trigger is forced to 0.
  - Trigger i+1 does not fire by itself if it is chained from i; it only qualifies i.
- Fire condition and pulse:
  - fire_i = qualified match AND action=1 AND dbg_mode=0 AND breakpoint=0.
  - When any trigger fires, breakpoint is registered high on the next edge, so latency is 1 cycle from the match cycle.
  - breakpoint is high for exactly 1 cycle, then returns to 0.
  - Back-to-back matches therefore produce pulses at most every other cycle.
  - In the dbg_mode=1 cycle there is no new pulse.
- Multiple firing triggers: the lowest index wins and is registered into trig_hit_idx; trig_hit_idx holds until the next fire.
- hit bit:
  - Sticky, set on every trigger i that fires, including during suppression by action=0 only if its match is qualified.
  - Cleared only by a CSR write of 0.
  - If a CSR write to the same tdata1 and a hardware hit set occur in the same cycle, the CSR write value wins.
- Match timing vs CSR writes: the match in a cycle uses the register values before that cycle's CSR write.
- Reset mid-pulse: breakpoint drops to 0 immediately and asynchronously.

Test Plan:
1. Reset → csr_rdata at 0x7A1 = 0x2000_0000 and breakpoint=0. Then write tselect=5 → reading 0x7A0 returns 0.
2. Trigger0: tdata2=0x0000_1000, tdata1=0x0000_1044 (action=1, m, execute); drive ex_valid=1, ex_pc=0x1000 in cycle N → breakpoint=1 in cycle N+1 only, trig_hit_idx=0, tdata1 read = 0x2010_1044.
3. Trigger1: store at 0x2000_0040 (tdata1=0x0000_1042); a load to the same address gives no pulse; a store to it gives a pulse with trig_hit_idx=1. Re-run the store with dbg_mode=1 → no pulse.
4. Chain: trigger0 execute at 0x100 with chain=1, trigger1 load at 0x8000. PC match alone gives no pulse; PC match plus load match in the same cycle gives a pulse with idx=0. Load match alone gives no pulse.
5. dmode: in debug mode, write tdata1 with dmode=1. Then, with dbg_mode=0, write tdata2=0xFFFF_FFFF → readback unchanged.
6. Simultaneous events: ex_pc matches trigger0 and mem_addr matches trigger1 in the same cycle → single pulse with idx=0 and both hit bits set. A match held for 3 cycles → pulses in cycles N+1 and N+3.

Source files
------------

// File: rtl/dbg_trigger_unit.sv
// Hardware breakpoint unit: matches execute PC / load-store address against mcontrol-style triggers and raises a debug-entry pulse.
// Latency: breakpoint is registered 1 cycle after the matching cycle; CSR reads are combinational, CSR writes take effect next edge.
// Backpressure: none; every cycle is evaluated, and a pulse in flight blocks new fires for that cycle (pulses at most every other cycle).
module dbg_trigger_unit #(
    parameter int TRIG_NUM = 2,   // 1..4 triggers
    parameter int ADDR_W   = 32   // 1..32 address bits
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              dbg_mode,
    input  logic [11:0]       csr_addr,
    input  logic              csr_wr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              breakpoint,
    output logic [1:0]        trig_hit_idx
);

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [1:0]          r_tselect;
    logic [TRIG_NUM-1:0] r_dmode;
    logic [TRIG_NUM-1:0] r_hit;
    logic [TRIG_NUM-1:0] r_action;   // 1 = enter debug mode, 0 = no action
    logic [TRIG_NUM-1:0] r_chain;
    logic [TRIG_NUM-1:0] r_m;
    logic [TRIG_NUM-1:0] r_exec;
    logic [TRIG_NUM-1:0] r_store;
    logic [TRIG_NUM-1:0] r_load;
    logic [ADDR_W-1:0]   r_tdata2 [TRIG_NUM];
    logic                r_breakpoint;
    logic [1:0]          r_hit_idx;

    // ------------------------------------------------------------------
    // Combinational decode / match
    // ------------------------------------------------------------------
    logic [TRIG_NUM-1:0] w_sel;          // trigger currently addressed by tselect
    logic [TRIG_NUM-1:0] w_wr_t1;        // accepted tdata1 write per trigger
    logic [TRIG_NUM-1:0] w_wr_t2;        // accepted tdata2 write per trigger
    logic [TRIG_NUM-1:0] w_raw;          // raw address/PC match
    logic [TRIG_NUM-1:0] w_chain_ok;     // chain partner satisfied (or not chained)
    logic [TRIG_NUM-1:0] w_chained_from; // this trigger only qualifies its predecessor
    logic [TRIG_NUM-1:0] w_qual;         // qualified match
    logic [TRIG_NUM-1:0] w_hit_set;      // qualified match while unit is armed
    logic [TRIG_NUM-1:0] w_fire;         // hit with action=1
    logic [31:0]         w_tdata1_rd [TRIG_NUM];
    logic [1:0]          w_fire_idx;
    logic                w_armed;
    logic                w_tsel_wr;

    // No new fire while in debug mode or while the previous pulse is still high
    assign w_armed   = !dbg_mode && !r_breakpoint;
    assign w_tsel_wr = csr_wr && (csr_addr == CSR_TSELECT) && (csr_wdata < 32'(TRIG_NUM));

    genvar g;
    generate
        for (g = 0; g < TRIG_NUM; g++) begin : g_trig
            // Equality match against tdata2; m must be set for any match type
            assign w_raw[g] = r_m[g] && (
                   (r_exec[g]  && ex_valid  &&  (ex_pc    == r_tdata2[g]))
                || (r_store[g] && mem_valid &&  mem_we && (mem_addr == r_tdata2[g]))
                || (r_load[g]  && mem_valid && !mem_we && (mem_addr == r_tdata2[g])));

            if (g < TRIG_NUM - 1) begin : g_chain_next
                assign w_chain_ok[g] = !r_chain[g] || w_raw[g+1];
            end else begin : g_chain_last
                assign w_chain_ok[g] = 1'b1;
            end

            if (g > 0) begin : g_chain_prev
                assign w_chained_from[g] = r_chain[g-1];
            end else begin : g_chain_first
                assign w_chained_from[g] = 1'b0;
            end

            assign w_qual[g]    = w_raw[g] && w_chain_ok[g] && !w_chained_from[g];
            assign w_hit_set[g] = w_qual[g] && w_armed;
            assign w_fire[g]    = w_hit_set[g] && r_action[g];

            // action is read back as the 4-bit encoding 1 when set
            assign w_tdata1_rd[g] = {4'h2, r_dmode[g], 6'b0, r_hit[g], 4'b0,
                                     3'b0, r_action[g], r_chain[g], 4'b0,
                                     r_m[g], 3'b0, r_exec[g], r_store[g], r_load[g]};
        end
    endgenerate

    // Per-trigger select and write qualification; dmode triggers are locked outside debug mode
    always_comb begin
        w_sel   = '0;
        w_wr_t1 = '0;
        w_wr_t2 = '0;
        for (int i = 0; i < TRIG_NUM; i++) begin
            w_sel[i]   = (r_tselect == 2'(i));
            w_wr_t1[i] = csr_wr && (csr_addr == CSR_TDATA1) && w_sel[i] && (!r_dmode[i] || dbg_mode);
            w_wr_t2[i] = csr_wr && (csr_addr == CSR_TDATA2) && w_sel[i] && (!r_dmode[i] || dbg_mode);
        end
    end

    // Lowest-index firing trigger wins
    always_comb begin
        w_fire_idx = 2'd0;
        for (int i = TRIG_NUM - 1; i >= 0; i--) begin
            if (w_fire[i]) begin
                w_fire_idx = 2'(i);
            end
        end
    end

    // CSR read mux; unmapped addresses read as zero
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_TSELECT: csr_rdata = {30'd0, r_tselect};
            CSR_TDATA1: begin
                for (int i = 0; i < TRIG_NUM; i++) begin
                    if (w_sel[i]) begin
                        csr_rdata = w_tdata1_rd[i];
                    end
                end
            end
            CSR_TDATA2: begin
                for (int i = 0; i < TRIG_NUM; i++) begin
                    if (w_sel[i]) begin
                        csr_rdata = 32'(r_tdata2[i]);
                    end
                end
            end
            default: csr_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // tselect: out-of-range writes leave the current selection in place
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_tselect <= 2'd0;
        end else if (w_tsel_wr) begin
            r_tselect <= csr_wdata[1:0];
        end
    end

    // Trigger registers: sticky hit from hardware, overridden by a same-cycle CSR write
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_dmode  <= '0;
            r_hit    <= '0;
            r_action <= '0;
            r_chain  <= '0;
            r_m      <= '0;
            r_exec   <= '0;
            r_store  <= '0;
            r_load   <= '0;
            for (int i = 0; i < TRIG_NUM; i++) begin
                r_tdata2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TRIG_NUM; i++) begin
                if (w_hit_set[i]) begin
                    r_hit[i] <= 1'b1;
                end
                if (w_wr_t1[i]) begin
                    if (dbg_mode) begin
                        r_dmode[i] <= csr_wdata[27];
                    end
                    r_hit[i]    <= csr_wdata[20];
                    r_action[i] <= (csr_wdata[15:12] == 4'd1);
                    // The last trigger has no partner, so its chain bit stays clear
                    r_chain[i]  <= (i < TRIG_NUM - 1) ? csr_wdata[11] : 1'b0;
                    r_m[i]      <= csr_wdata[6];
                    r_exec[i]   <= csr_wdata[2];
                    r_store[i]  <= csr_wdata[1];
                    r_load[i]   <= csr_wdata[0];
                end
                if (w_wr_t2[i]) begin
                    r_tdata2[i] <= csr_wdata[ADDR_W-1:0];
                end
            end
        end
    end

    // Breakpoint pulse and hit index; the pulse self-clears because fires are blocked while it is high
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_breakpoint <= 1'b0;
            r_hit_idx    <= 2'd0;
        end else begin
            r_breakpoint <= |w_fire;
            if (|w_fire) begin
                r_hit_idx <= w_fire_idx;
            end
        end
    end

    assign breakpoint   = r_breakpoint;
    assign trig_hit_idx = r_hit_idx;

endmodule

// File: tb/tb_dbg_trigger_unit.sv
// Directed bench for dbg_trigger_unit: CSR programming, match types, chaining, dmode lock and pulse timing.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_dbg_trigger_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        dbg_mode;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        breakpoint;
    logic [1:0]  trig_hit_idx;

    int n_vec = 0;
    int n_err = 0;

    dbg_trigger_unit #(.TRIG_NUM(2), .ADDR_W(32)) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rstn     (cpu_rstn),
        .dbg_mode     (dbg_mode),
        .csr_addr     (csr_addr),
        .csr_wr       (csr_wr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .breakpoint   (breakpoint),
        .trig_hit_idx (trig_hit_idx)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wr    = 1'b1;
        tick();
        csr_wr    = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        cpu_rstn = 1'b0; dbg_mode = 1'b0; csr_addr = 12'h0; csr_wr = 1'b0; csr_wdata = 32'h0;
        ex_valid = 1'b0; ex_pc = 32'h0; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = 32'h0;
        #12;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL reset_bp: got %b want 0", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", trig_hit_idx); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_0000) begin n_err++; $display("FAIL reset_tdata1: got %h want 20000000", rd); end
        csr_read(12'h7A2, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_tdata2: got %h want 0", rd); end
        #8;
        cpu_rstn = 1'b1;
        tick();
        csr_write(12'h7A0, 32'd5);
        csr_read(12'h7A0, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL tsel_5: got %h want 0", rd); end
        csr_write(12'h7A0, 32'd1);
        csr_read(12'h7A0, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL tsel_1: got %h want 1", rd); end
        csr_write(12'h7A0, 32'd2);
        csr_read(12'h7A0, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL tsel_2_ignored: got %h want 1", rd); end
    endtask

    task automatic test_execute();
        logic [31:0] rd;
        csr_write(12'h7A0, 32'd0);
        csr_write(12'h7A1, 32'hFFFF_FFFF);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_0847) begin n_err++; $display("FAIL t1_allones: got %h want 20100847", rd); end
        csr_write(12'h7A2, 32'h0000_1000);
        csr_write(12'h7A1, 32'h0000_1044);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_1044) begin n_err++; $display("FAIL t1_exec_prog: got %h want 20001044", rd); end
        csr_read(12'h7A2, rd);
        n_vec++; if (rd !== 32'h0000_1000) begin n_err++; $display("FAIL t2_readback: got %h want 00001000", rd); end
        csr_read(12'h7A3, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h want 0", rd); end
        ex_valid = 1'b1; ex_pc = 32'h0000_1004;
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL exec_wrong_pc: got %b want 0", breakpoint); end
        ex_pc = 32'h0000_1000;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL exec_cycle_n: got %b want 0", breakpoint); end
        tick();
        ex_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1) begin n_err++; $display("FAIL exec_pulse: got %b want 1", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd0) begin n_err++; $display("FAIL exec_idx: got %0d want 0", trig_hit_idx); end
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL exec_pulse_end: got %b want 0", breakpoint); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_1044) begin n_err++; $display("FAIL exec_hit: got %h want 20101044", rd); end
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL exec_invalid: got %b want 0", breakpoint); end
        csr_write(12'h7A1, 32'h0);
    endtask

    task automatic test_store();
        logic [31:0] rd;
        csr_write(12'h7A0, 32'd1);
        csr_write(12'h7A1, 32'h0000_1842);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_1042) begin n_err++; $display("FAIL last_chain_forced0: got %h want 20001042", rd); end
        csr_write(12'h7A2, 32'h2000_0040);
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000_0040;
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL store_trig_on_load: got %b want 0", breakpoint); end
        mem_we = 1'b1;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1) begin n_err++; $display("FAIL store_pulse: got %b want 1", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd1) begin n_err++; $display("FAIL store_idx: got %0d want 1", trig_hit_idx); end
        tick();
        dbg_mode = 1'b1; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL store_dbg_mode: got %b want 0", breakpoint); end
        dbg_mode = 1'b0;
        csr_write(12'h7A1, 32'h0000_0042);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL store_action0: got %b want 0", breakpoint); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_0042) begin n_err++; $display("FAIL action0_hit: got %h want 20100042", rd); end
        csr_write(12'h7A1, 32'h0);
    endtask

    task automatic test_chain();
        logic [31:0] rd;
        csr_write(12'h7A0, 32'd0);
        csr_write(12'h7A2, 32'h0000_0100);
        csr_write(12'h7A1, 32'h0000_1844);
        csr_write(12'h7A0, 32'd1);
        csr_write(12'h7A2, 32'h0000_8000);
        csr_write(12'h7A1, 32'h0000_1041);
        ex_valid = 1'b1; ex_pc = 32'h0000_0100;
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL chain_pc_only: got %b want 0", breakpoint); end
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_8000;
        tick();
        ex_valid = 1'b0; mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1) begin n_err++; $display("FAIL chain_both: got %b want 1", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd0) begin n_err++; $display("FAIL chain_idx: got %0d want 0", trig_hit_idx); end
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL chain_load_only: got %b want 0", breakpoint); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_1041) begin n_err++; $display("FAIL chain_t1_nohit: got %h want 20001041", rd); end
        csr_write(12'h7A1, 32'h0);
        csr_write(12'h7A0, 32'd0);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_1844) begin n_err++; $display("FAIL chain_t0_hit: got %h want 20101844", rd); end
        csr_write(12'h7A1, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        exp_bp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        csr_write(12'h7A0, 32'd0);
        csr_write(12'h7A2, 32'h0000_3000);
        csr_write(12'h7A1, 32'h0000_1044);
        csr_write(12'h7A0, 32'd1);
        csr_write(12'h7A2, 32'h0000_4000);
        csr_write(12'h7A1, 32'h0000_1042);
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_4000;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (trig_hit_idx !== 2'd1) begin n_err++; $display("FAIL solo_store_idx: got %0d want 1", trig_hit_idx); end
        tick();
        csr_write(12'h7A1, 32'h0000_1042);
        ex_valid = 1'b1; ex_pc = 32'h0000_3000; mem_valid = 1'b1;
        tick();
        ex_valid = 1'b0; mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1) begin n_err++; $display("FAIL simul_pulse: got %b want 1", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd0) begin n_err++; $display("FAIL simul_idx: got %0d want 0", trig_hit_idx); end
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL simul_single: got %b want 0", breakpoint); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_1042) begin n_err++; $display("FAIL simul_t1_hit: got %h want 20101042", rd); end
        csr_write(12'h7A1, 32'h0);
        csr_write(12'h7A0, 32'd0);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2010_1044) begin n_err++; $display("FAIL simul_t0_hit: got %h want 20101044", rd); end
        ex_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 2) ex_valid = 1'b0;
            n_vec++;
            if (breakpoint !== exp_bp[c]) begin
                n_err++; $display("FAIL held_match_cycle%0d: got %b want %b", c + 1, breakpoint, exp_bp[c]);
            end
        end
        // Match and CSR write on the same edge: old config fires, written hit=0 wins
        ex_valid = 1'b1;
        csr_write(12'h7A1, 32'h0);
        ex_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1) begin n_err++; $display("FAIL wr_same_cycle_pulse: got %b want 1", breakpoint); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_0000) begin n_err++; $display("FAIL wr_beats_hit: got %h want 20000000", rd); end
        csr_write(12'h7A1, 32'h0000_1044);
    endtask

    task automatic test_dmode();
        logic [31:0] rd;
        csr_write(12'h7A0, 32'd0);
        dbg_mode = 1'b1;
        csr_write(12'h7A1, 32'h0800_1044);
        dbg_mode = 1'b0;
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2800_1044) begin n_err++; $display("FAIL dmode_set: got %h want 28001044", rd); end
        csr_write(12'h7A1, 32'h0);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2800_1044) begin n_err++; $display("FAIL dmode_t1_locked: got %h want 28001044", rd); end
        csr_write(12'h7A2, 32'hFFFF_FFFF);
        csr_read(12'h7A2, rd);
        n_vec++; if (rd !== 32'h0000_3000) begin n_err++; $display("FAIL dmode_t2_locked: got %h want 00003000", rd); end
        csr_write(12'h7A0, 32'd1);
        csr_write(12'h7A1, 32'h0800_1042);
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_1042) begin n_err++; $display("FAIL dmode_needs_dbg: got %h want 20001042", rd); end
        csr_write(12'h7A2, 32'h0000_5000);
        csr_read(12'h7A2, rd);
        n_vec++; if (rd !== 32'h0000_5000) begin n_err++; $display("FAIL t2_unlocked: got %h want 00005000", rd); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] rd;
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_5000;
        tick();
        mem_valid = 1'b0;
        n_vec++; if (breakpoint !== 1'b1 || trig_hit_idx !== 2'd1) begin
            n_err++; $display("FAIL pre_reset_pulse: got bp=%b idx=%0d want bp=1 idx=1", breakpoint, trig_hit_idx);
        end
        #2;
        cpu_rstn = 1'b0;
        #1;
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL async_reset_bp: got %b want 0", breakpoint); end
        n_vec++; if (trig_hit_idx !== 2'd0) begin n_err++; $display("FAIL async_reset_idx: got %0d want 0", trig_hit_idx); end
        csr_read(12'h7A1, rd);
        n_vec++; if (rd !== 32'h2000_0000) begin n_err++; $display("FAIL async_reset_tdata1: got %h want 20000000", rd); end
        #1;
        cpu_rstn = 1'b1;
        tick();
        n_vec++; if (breakpoint !== 1'b0) begin n_err++; $display("FAIL post_reset_bp: got %b want 0", breakpoint); end
    endtask

    initial begin
        test_reset();
        test_execute();
        test_store();
        test_chain();
        test_back_to_back();
        test_dmode();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
